// File: rtl/regfile_scan_reader_pkg.sv
// Shared register-file geometry and scan-reader FSM state codes.
package regfile_scan_reader_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 32;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

endpackage

// File: rtl/regfile_scan_reader.sv
// Sweeps the register file two registers per cycle and streams each pair out
// through a one-entry valid/ready stage, accumulating an XOR checksum.
module regfile_scan_reader
    import regfile_scan_reader_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = REG_NUM
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    output logic [ADDR_W-1:0]   ReadReg1,
    output logic [ADDR_W-1:0]   ReadReg2,
    input  logic [DATA_W-1:0]   ReadData1,
    input  logic [DATA_W-1:0]   ReadData2,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [2*DATA_W-1:0] OutData,
    output logic [ADDR_W-2:0]   OutIndex,
    output logic                Busy,
    output logic                Done,
    output logic [2*DATA_W-1:0] Checksum
);

    localparam int NUM_PAIRS = NUM_REGS / 2;
    localparam int CTR_W     = ADDR_W - 1;

    logic [1:0]          state;
    logic [CTR_W-1:0]    ctr;
    logic                load;
    logic                lastPair;
    logic [2*DATA_W-1:0] pairData;

    // The pair counter addresses both read ports directly, so a stalled
    // output stage also freezes the register indices.
    assign ReadReg1 = {ctr, 1'b0};
    assign ReadReg2 = {ctr, 1'b1};

    assign pairData = {ReadData2, ReadData1};
    assign load     = (state == S_SCAN) && (!OutValid || OutReady);
    assign lastPair = (ctr == CTR_W'(NUM_PAIRS - 1));
    assign Busy     = (state != S_IDLE);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= S_IDLE;
            ctr      <= '0;
            OutValid <= 1'b0;
            OutData  <= '0;
            OutIndex <= '0;
            Done     <= 1'b0;
            Checksum <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state    <= S_SCAN;
                        ctr      <= '0;
                        Checksum <= '0;
                    end
                end
                S_SCAN: begin
                    if (load) begin
                        OutData  <= pairData;
                        OutIndex <= ctr;
                        OutValid <= 1'b1;
                        Checksum <= Checksum ^ pairData;
                        // Counter parks on the last pair instead of wrapping.
                        if (lastPair) begin
                            state <= S_DRAIN;
                        end else begin
                            ctr <= ctr + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (OutValid && OutReady) begin
                        OutValid <= 1'b0;
                        Done     <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
